mem_responder: RTL and testbench

- Memory-side responder for the multicycle MIPS core's unified instruction/data memory port.
- Accepts one word read or write request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a held response until the core acknowledges it.
- Replaces the zero-latency memory so the control FSM can be exercised against a slow memory.

---
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder with valid/ready request and response channels and a
// fixed number of wait states. Define MEM_ERR_EN to flag misaligned/out-of-range accesses.
module mem_responder #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    // Handshakes: a request transfers on a rising edge with req_valid & req_ready; the
    // response is held with resp_valid until a rising edge sees resp_ready high.
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              accept, enter_resp;
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              op_we, op_err;
    logic [ADDR_W-1:0] op_idx;
    logic [31:0]       op_wdata;
    logic [31:0]       mem [2**ADDR_W];

    assign req_ready = (state == IDLE) && !reset;

    // With zero wait states RESP is entered on the accept edge, so the live request is used.
    always_comb begin
        op_we    = we_q;
        op_idx   = idx_q;
        op_wdata = wdata_q;
        if (state == IDLE) begin
            op_we    = req_we;
            op_idx   = req_addr[ADDR_W+1:2];
            op_wdata = req_wdata;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_rdata <= (op_we || op_err) ? 32'd0 : mem[op_idx];
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
        end
    end

    // Array is deliberately not reset; a write commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && op_we && !op_err) mem[op_idx] <= op_wdata;
    end

`ifdef MEM_ERR_EN
    logic err_acc, err_q, err_r;

    assign err_acc  = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign op_err   = (state == IDLE) ? err_acc : err_q;
    assign resp_err = err_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (accept) err_q <= err_acc;
            if (enter_resp) err_r <= op_err;
            else if (state == RESP && resp_ready) err_r <= 1'b0;
        end
    end
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign op_err           = 1'b0;
    assign resp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(6), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full transaction on the WAIT instance with resp_ready held high.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
        @(negedge clk);
        chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = $urandom_range(0, 255);
        req_wdata = $urandom();
        for (int i = 0; i < WAIT; i++) begin
            chk({tag, " busy_valid"}, 32'(resp_valid), 32'd0);
            chk({tag, " busy_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_ready_low"}, 32'(req_ready), 32'd0);
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, " cleared_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " cleared_rdata"}, resp_rdata, 32'd0);
        chk({tag, " back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        {req_valid, req_we, resp_ready} = '0;
        req_addr = '0; req_wdata = '0;
        {z_req_valid, z_req_we, z_resp_ready} = '0;
        z_req_addr = '0; z_req_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_z_req_ready", 32'(z_req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Write then read-after-write
        xact("wr10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        xact("rd10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Zero wait states: write then read, back-to-back as fast as allowed
        @(negedge clk);
        chk("z_idle", 32'(z_req_ready), 32'd1);
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h0; z_req_wdata = 32'hA5A5_5A5A;
        z_resp_ready = 1'b1;
        @(negedge clk);
        chk("z_wr_valid", 32'(z_resp_valid), 32'd1);
        chk("z_wr_rdata", z_resp_rdata, 32'd0);
        chk("z_wr_busy", 32'(z_req_ready), 32'd0);
        z_req_we = 1'b0; z_req_addr = 32'h0;
        @(negedge clk);
        chk("z_accept_again", 32'(z_req_ready), 32'd1);
        chk("z_gap_valid", 32'(z_resp_valid), 32'd0);
        @(negedge clk);
        z_req_valid = 1'b0;
        chk("z_rd_valid", 32'(z_resp_valid), 32'd1);
        chk("z_rd_rdata", z_resp_rdata, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("z_rd_done", 32'(z_resp_valid), 32'd0);

        // Backpressure with ignored request pulses during RESP
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (WAIT) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0]; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0000_0BAD;
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        chk("bp_still_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("bp_released", 32'(resp_valid), 32'd0);
        chk("bp_idle", 32'(req_ready), 32'd1);
        xact("bp_recheck", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

`ifdef MEM_ERR_EN
        xact("e_init0", 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'd0, 1'b0);
        xact("e_misalign", 1'b1, 32'h0000_0102, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xact("e_mem0", 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1'b0);
        xact("e_range", 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xact("e_mem0b", 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 1'b0);
        xact("e_init8", 1'b1, 32'h0000_0008, 32'h8888_0008, 32'd0, 1'b0);
        xact("e_rd8", 1'b0, 32'h0000_0008, 32'h0, 32'h8888_0008, 1'b0);
`else
        xact("al_wr104", 1'b1, 32'h0000_0104, 32'h1234_5678, 32'd0, 1'b0);
        xact("al_rd004", 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0);
        xact("al_rd007", 1'b0, 32'h0000_0007, 32'h0, 32'h1234_5678, 1'b0);
`endif

        // Reset during BUSY aborts a pending write
        xact("pre20", 1'b1, 32'h0000_0020, 32'h1111_1111, 32'd0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        xact("rd20", 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
